id_ex_stage: RTL
================

// Module: id_ex_stage
// PURPOSE
//  Decode-to-execute pipeline register for the MIPS pipeline. It captures the Control unit's
//  signals, register-file operands, sign-extended immediate, register indices and PC+4 at the
//  end of ID. It detects load-use hazards, stalls the front end and inserts bubbles. It also
//  squashes the ID instruction on a taken-branch flush and counts stall cycles.
// PARAMETERS
//  DATA_W   32  width of operands, immediate and PC+4
//  REG_W     5  register index width
//  CNT_W    16  width of saturating stall counter
// PORTS
//  clk            in   1       rising-edge clock
//  reset          in   1       synchronous, active-low reset
//  id_valid_i     in   1       ID slot holds a real instruction
//  flush_i        in   1       squash ID instruction (taken branch resolved)
//  reg_dst_i..reg_write_i  in  1 each  Control outputs (8 single-bit signals)
//  alu_op_i       in   3       Control ALU op
//  read_data_1_i  in   DATA_W  rs operand
//  read_data_2_i  in   DATA_W  rt operand
//  imm_ext_i      in   DATA_W  sign-extended immediate
//  pc_plus4_i     in   DATA_W  PC+4 of ID instruction
//  rs_i,rt_i,rd_i in   REG_W   register indices
//  *_o            out  same    registered copies of every input above except flush_i
//  ex_valid_o     out  1       EX slot holds a real instruction
//  stall_o        out  1       comb.: hold PC and IF/ID this cycle
//  stall_count_o  out  CNT_W   saturating count of cycles in which stall_o was high
// BEHAVIOUR
//  - Reset (reset==0 at posedge): all registered outputs 0; ex_valid_o=0; stall_count_o=0.
//  - Latency: one cycle, from ID inputs to the *_o outputs.
//  - Hazard (comb.): stall_o = id_valid_i & ex_valid_o & ex mem_read_o & (ex rt_o != 0)
//    & ((rt_o==rs_i) | (rt_o==rt_i & reads_rt)).
//    reads_rt = reg_dst_i | mem_write_i | branch_eq_i | branch_ne_i.
//  - Update priority at posedge: reset > flush_i > stall_o > normal load.
//  - flush_i or stall_o: load a bubble. All 11 control bits are 0 and ex_valid_o=0.
//    Data, index and PC fields load their inputs; they are don't-care but deterministic.
//  - Normal: every *_o <= input; ex_valid_o <= id_valid_i.
//    If id_valid_i==0, the control bits are forced to 0.
//  - A stall lasts exactly one cycle: the bubble has mem_read_o=0, which deasserts stall_o.
//  - flush_i together with stall_o: flush wins. A bubble is inserted and stall_o stays
//    asserted, because the front end handles the redirect.
//  - stall_count_o increments when stall_o=1 and flush_i=0, and saturates at 2^CNT_W-1.
//  - Reset asserted mid-stall: outputs and counter clear, and stall_o falls the same cycle
//    because ex_valid_o=0.
// STRUCTURE
//  - Shared package holds: CTRL_W=11; control-bit index localparams matching the Control
//    bundle order (reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch_ne,
//    branch_eq, alu_op[2:0]); ALU_OP_RTYPE=3'b111, ADDI=3'b100, ORI=3'b101, LUI=3'b110;
//    REG_ZERO=5'd0.
//  - One combinational sub-module, hazard_detect_unit, produces stall_o.
//    The top level holds the registers and the counter.
// TESTING
//  1 Reset: reset=0 for 2 cycles with random inputs. All *_o=0, ex_valid_o=0, stall_count_o=0.
//  2 Pass-through: ADDI (alu_src=1, reg_write=1, alu_op=100, rs=3, rt=4, imm=0x0000_0010).
//    One cycle later the *_o outputs equal those values and ex_valid_o=1.
//  3 Load-use: EX holds lw with rt=8 (mem_read=1); ID holds R-type with rs=8.
//    stall_o=1; next cycle control outputs are all 0 and ex_valid_o=0; stall_count_o=1.
//    The following cycle stall_o=0 and the R-type loads.
//  4 No false stall: EX lw rt=0 with ID rs=0 -> stall_o=0.
//    EX lw rt=9 with ID ORI rt=9 and rs=2 -> stall_o=0, since ORI does not read rt.
//  5 Flush priority: flush_i=1 during a load-use stall. Bubble inserted, stall_count_o
//    unchanged; with flush_i=1 and no hazard, ex_valid_o=0 next cycle.
//  6 Saturation (CNT_W=4): force 20 stall cycles -> stall_count_o stays at 15.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline register: control bundle layout,
// ALU op encodings and register-index constants.
package id_ex_stage_pkg;

  localparam int CTRL_W = 11;

  // Bit positions inside the packed Control bundle, MSB first
  localparam int CTRL_REG_DST    = 10;
  localparam int CTRL_ALU_SRC    = 9;
  localparam int CTRL_MEM_TO_REG = 8;
  localparam int CTRL_REG_WRITE  = 7;
  localparam int CTRL_MEM_READ   = 6;
  localparam int CTRL_MEM_WRITE  = 5;
  localparam int CTRL_BRANCH_NE  = 4;
  localparam int CTRL_BRANCH_EQ  = 3;
  localparam int CTRL_ALU_OP_HI  = 2;
  localparam int CTRL_ALU_OP_LO  = 0;

  localparam logic [2:0] ALU_OP_RTYPE = 3'b111;
  localparam logic [2:0] ALU_OP_ADDI  = 3'b100;
  localparam logic [2:0] ALU_OP_ORI   = 3'b101;
  localparam logic [2:0] ALU_OP_LUI   = 3'b110;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // An instruction consumes rt as a source when it is R-type, a store or a branch
  function automatic logic ctrl_reads_rt(input logic [CTRL_W-1:0] ctrl);
    return ctrl[CTRL_REG_DST] | ctrl[CTRL_MEM_WRITE] |
           ctrl[CTRL_BRANCH_EQ] | ctrl[CTRL_BRANCH_NE];
  endfunction

endpackage

// File: rtl/id_ex_stage_hazard.sv
// Load-use hazard detection: stalls when the load in EX writes a register
// that the instruction in ID needs as a source.
module hazard_detect_unit
  import id_ex_stage_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             id_valid,
  input  logic             id_reads_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  output logic             stall
);

  logic ex_load_live;
  logic rs_match;
  logic rt_match;

  // Loads targeting $zero never produce a real dependency
  assign ex_load_live = ex_valid & ex_mem_read & (ex_rt != REG_W'(REG_ZERO));
  assign rs_match     = (ex_rt == id_rs);
  assign rt_match     = (ex_rt == id_rt) & id_reads_rt;
  assign stall        = id_valid & ex_load_live & (rs_match | rt_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, branch flush bubbles and a
// saturating stall-cycle counter.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid_i,
  input  logic              flush_i,
  input  logic              reg_dst_i,
  input  logic              alu_src_i,
  input  logic              mem_to_reg_i,
  input  logic              reg_write_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic              branch_ne_i,
  input  logic              branch_eq_i,
  input  logic [2:0]        alu_op_i,
  input  logic [DATA_W-1:0] read_data_1_i,
  input  logic [DATA_W-1:0] read_data_2_i,
  input  logic [DATA_W-1:0] imm_ext_i,
  input  logic [DATA_W-1:0] pc_plus4_i,
  input  logic [REG_W-1:0]  rs_i,
  input  logic [REG_W-1:0]  rt_i,
  input  logic [REG_W-1:0]  rd_i,
  output logic              reg_dst_o,
  output logic              alu_src_o,
  output logic              mem_to_reg_o,
  output logic              reg_write_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic              branch_ne_o,
  output logic              branch_eq_o,
  output logic [2:0]        alu_op_o,
  output logic [DATA_W-1:0] read_data_1_o,
  output logic [DATA_W-1:0] read_data_2_o,
  output logic [DATA_W-1:0] imm_ext_o,
  output logic [DATA_W-1:0] pc_plus4_o,
  output logic [REG_W-1:0]  rs_o,
  output logic [REG_W-1:0]  rt_o,
  output logic [REG_W-1:0]  rd_o,
  output logic              ex_valid_o,
  output logic              stall_o,
  output logic [CNT_W-1:0]  stall_count_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CTRL_W-1:0] ctrl_in;
  logic [CTRL_W-1:0] ctrl_q;
  logic              bubble;

  assign ctrl_in = {reg_dst_i, alu_src_i, mem_to_reg_i, reg_write_i,
                    mem_read_i, mem_write_i, branch_ne_i, branch_eq_i, alu_op_i};

  hazard_detect_unit #(
    .REG_W(REG_W)
  ) u_hazard (
    .id_valid    (id_valid_i),
    .id_reads_rt (ctrl_reads_rt(ctrl_in)),
    .id_rs       (rs_i),
    .id_rt       (rt_i),
    .ex_valid    (ex_valid_o),
    .ex_mem_read (mem_read_o),
    .ex_rt       (rt_o),
    .stall       (stall_o)
  );

  assign bubble = flush_i | stall_o;

  // Data fields always follow their inputs; only control and valid are squashed
  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl_q        <= '0;
      ex_valid_o    <= 1'b0;
      read_data_1_o <= '0;
      read_data_2_o <= '0;
      imm_ext_o     <= '0;
      pc_plus4_o    <= '0;
      rs_o          <= '0;
      rt_o          <= '0;
      rd_o          <= '0;
    end else begin
      read_data_1_o <= read_data_1_i;
      read_data_2_o <= read_data_2_i;
      imm_ext_o     <= imm_ext_i;
      pc_plus4_o    <= pc_plus4_i;
      rs_o          <= rs_i;
      rt_o          <= rt_i;
      rd_o          <= rd_i;
      if (bubble) begin
        ctrl_q     <= '0;
        ex_valid_o <= 1'b0;
      end else begin
        ctrl_q     <= id_valid_i ? ctrl_in : '0;
        ex_valid_o <= id_valid_i;
      end
    end
  end

  // A flushed cycle is not counted: the redirect, not the hazard, owns it
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_count_o <= '0;
    end else if (stall_o && !flush_i && stall_count_o != CNT_MAX) begin
      stall_count_o <= stall_count_o + 1'b1;
    end
  end

  assign reg_dst_o    = ctrl_q[CTRL_REG_DST];
  assign alu_src_o    = ctrl_q[CTRL_ALU_SRC];
  assign mem_to_reg_o = ctrl_q[CTRL_MEM_TO_REG];
  assign reg_write_o  = ctrl_q[CTRL_REG_WRITE];
  assign mem_read_o   = ctrl_q[CTRL_MEM_READ];
  assign mem_write_o  = ctrl_q[CTRL_MEM_WRITE];
  assign branch_ne_o  = ctrl_q[CTRL_BRANCH_NE];
  assign branch_eq_o  = ctrl_q[CTRL_BRANCH_EQ];
  assign alu_op_o     = ctrl_q[CTRL_ALU_OP_HI:CTRL_ALU_OP_LO];

endmodule
